water_supply_arbiter: RTL

Shares one mains water inlet valve between N washing_machine_controller instances in a multi-machine laundry build. Each machine's water_in becomes a request. The arbiter grants the valve round-robin, enforces a maximum fill time per grant, honours per-machine pause, and inserts a valve-settle gap between grants. It sits between the controllers and the physical valve driver.

---
 rtl/water_arb_pkg.sv | 20 ++
 rtl/water_supply_arbiter_rr_pick.sv | 38 +++
 rtl/water_supply_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/water_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : water_arb_pkg
// Brief    : State encoding and statistics widths for the water supply arbiter.
// Revision : 1.0
// ============================================================================
package water_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    PAUSED = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  localparam int c_grant_cnt_w   = 16;
  localparam int c_timeout_cnt_w = 8;

endpackage
`default_nettype wire

// File: rtl/water_supply_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin finder: first set bit at or above the
//            pointer, wrapping around.
// Revision : 1.0
// ============================================================================
module rr_pick #(
  parameter int N_MACH = 4,
  parameter int ID_W   = $clog2(N_MACH)
) (
  input  logic [N_MACH-1:0] i_eligible,
  input  logic [ID_W-1:0]   i_rr_ptr,
  output logic              o_valid,
  output logic [ID_W-1:0]   o_idx
);

  logic [ID_W:0] w_pos;

  // Scan offsets from the far end down so the nearest candidate is written last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int k = N_MACH - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_rr_ptr} + (ID_W+1)'(k);
      if (w_pos >= (ID_W+1)'(N_MACH)) begin
        w_pos = w_pos - (ID_W+1)'(N_MACH);
      end
      if (i_eligible[w_pos[ID_W-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/water_supply_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : water_supply_arbiter
// Brief    : Round-robin owner of the shared inlet valve with fill timeout,
//            pause and settle gap. WATER_ARB_STATS_EN adds grant/timeout counters.
// Revision : 1.0
// ============================================================================
module water_supply_arbiter
  import water_arb_pkg::*;
#(
  parameter int N_MACH     = 4,
  parameter int MAX_FILL   = 1000,
  parameter int GAP_CYCLES = 4,
  parameter int TIMER_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      power,
  input  logic [N_MACH-1:0]         req,
  input  logic [N_MACH-1:0]         hold,
  output logic [N_MACH-1:0]         grant,
  output logic                      valve_open,
  output logic [$clog2(N_MACH)-1:0] active_id,
  output logic                      busy,
  output logic [N_MACH-1:0]         timeout_flag
`ifdef WATER_ARB_STATS_EN
  ,
  output logic [c_grant_cnt_w-1:0]  grant_count,
  output logic [c_timeout_cnt_w-1:0] timeout_count
`endif
);

  localparam int                c_id_w = $clog2(N_MACH);
  localparam logic [N_MACH-1:0] c_one  = N_MACH'(1);

  arb_state_t          r_state;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [TIMER_W-1:0]  r_timer;

  logic [N_MACH-1:0]   w_eligible;
  logic [N_MACH-1:0]   w_flag_set;
  logic                w_pick_valid;
  logic [c_id_w-1:0]   w_pick_idx;
  logic [c_id_w-1:0]   w_next_ptr;
  logic                w_act_req;
  logic                w_act_hold;
  logic                w_fill_expired;
  logic                w_timeout;
  logic                w_release;

  assign w_eligible     = req & ~timeout_flag;
  assign w_act_req      = req[active_id];
  assign w_act_hold     = hold[active_id];
  assign w_fill_expired = (r_timer == TIMER_W'(MAX_FILL - 1));
  // A request drop on the expiry edge is a normal release, not a fault.
  assign w_timeout      = power && (r_state == FILL) && w_act_req && w_fill_expired;
  assign w_release      = power && (((r_state == FILL) && (!w_act_req || w_fill_expired)) ||
                                    ((r_state == PAUSED) && !w_act_req));
  assign w_flag_set     = w_timeout ? (c_one << active_id) : '0;
  assign w_next_ptr     = (int'(active_id) == N_MACH - 1) ? '0 : active_id + c_id_w'(1);
  assign busy           = (r_state != IDLE);

  rr_pick #(
    .N_MACH (N_MACH),
    .ID_W   (c_id_w)
  ) u_rr_pick (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_valid    (w_pick_valid),
    .o_idx      (w_pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      grant         <= '0;
      valve_open    <= 1'b0;
      active_id     <= '0;
      timeout_flag  <= '0;
      r_rr_ptr      <= '0;
      r_timer       <= '0;
`ifdef WATER_ARB_STATS_EN
      grant_count   <= '0;
      timeout_count <= '0;
`endif
    end else begin
      timeout_flag <= (timeout_flag | w_flag_set) & req;
      if (!power) begin
        r_state    <= IDLE;
        grant      <= '0;
        valve_open <= 1'b0;
        r_timer    <= '0;
      end else if (w_release) begin
        r_state    <= GAP;
        grant      <= '0;
        valve_open <= 1'b0;
        r_rr_ptr   <= w_next_ptr;
        r_timer    <= '0;
`ifdef WATER_ARB_STATS_EN
        if (w_timeout && (timeout_count != '1)) begin
          timeout_count <= timeout_count + c_timeout_cnt_w'(1);
        end
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pick_valid) begin
              r_state    <= FILL;
              grant      <= c_one << w_pick_idx;
              valve_open <= 1'b1;
              active_id  <= w_pick_idx;
              r_timer    <= '0;
`ifdef WATER_ARB_STATS_EN
              if (grant_count != '1) begin
                grant_count <= grant_count + c_grant_cnt_w'(1);
              end
`endif
            end
          end
          FILL: begin
            r_timer <= r_timer + TIMER_W'(1);
            if (w_act_hold) begin
              r_state    <= PAUSED;
              valve_open <= 1'b0;
            end
          end
          PAUSED: begin
            // Timer stays frozen; only valve-open cycles count towards the limit.
            if (!w_act_hold) begin
              r_state    <= FILL;
              valve_open <= 1'b1;
            end
          end
          GAP: begin
            if (r_timer == TIMER_W'(GAP_CYCLES - 1)) begin
              r_state <= IDLE;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + TIMER_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
